// File: rtl/window_addr_gen_pkg.sv
// Shared types for the window address generator: FSM state encoding and default widths.
package window_addr_gen_pkg;

    localparam int unsigned WAG_ADDR_WIDTH = 8;

    typedef enum logic {
        WAG_IDLE,
        WAG_EMIT
    } wag_state_t;

endpackage

// File: rtl/window_addr_gen_if.sv
// Coordinate-in / address-out stream bundle for window_addr_gen.
interface window_addr_gen_if #(
    parameter int unsigned ADDR_WIDTH = 8
) ();
    logic                  i_coord_valid;
    logic [ADDR_WIDTH-1:0] i_coord_x;
    logic [ADDR_WIDTH-1:0] i_coord_y;
    logic                  o_coord_ready;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [ADDR_WIDTH-1:0] o_kx;
    logic [ADDR_WIDTH-1:0] o_ky;
    logic                  o_valid;
    logic                  i_ready;
    logic                  o_last;

    modport slave (
        input  i_coord_valid, i_coord_x, i_coord_y, i_ready,
        output o_coord_ready, o_addr, o_kx, o_ky, o_valid, o_last
    );

    modport master (
        output i_coord_valid, i_coord_x, i_coord_y, i_ready,
        input  o_coord_ready, o_addr, o_kx, o_ky, o_valid, o_last
    );
endinterface

// File: rtl/window_addr_gen_kernel_pos_counter.sv
// 2-D kernel position counter: ky runs fastest, wraps into kx; flags the final position.
module kernel_pos_counter #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_nrst,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic         i_advance,
    input  logic [W-1:0] i_k,
    output logic [W-1:0] o_kx,
    output logic [W-1:0] o_ky,
    output logic         o_last,
    output logic         o_wrap_c
);
    logic [W-1:0] kmax_q;
    logic [W-1:0] load_kmax_c;
    logic         ky_end_c;

    // K of zero behaves as K of one, so the bound is clamped at zero
    assign load_kmax_c = (i_k == '0) ? '0 : W'(i_k - W'(1));
    assign ky_end_c    = (o_ky == kmax_q);
    assign o_wrap_c    = i_advance & ~o_last & ky_end_c;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_kx   <= '0;
            o_ky   <= '0;
            o_last <= 1'b0;
            kmax_q <= '0;
        end else if (i_clear) begin
            o_kx   <= '0;
            o_ky   <= '0;
            o_last <= 1'b0;
        end else if (i_load) begin
            o_kx   <= '0;
            o_ky   <= '0;
            kmax_q <= load_kmax_c;
            o_last <= (load_kmax_c == '0);
        end else if (i_advance) begin
            if (o_last) begin
                o_kx   <= '0;
                o_ky   <= '0;
                o_last <= 1'b0;
            end else if (ky_end_c) begin
                // a wrap lands on column zero, which is never last when K > 1
                o_ky   <= '0;
                o_kx   <= W'(o_kx + W'(1));
                o_last <= 1'b0;
            end else begin
                o_ky   <= W'(o_ky + W'(1));
                o_last <= (o_kx == kmax_q) && (W'(o_ky + W'(1)) == kmax_q);
            end
        end
    end
endmodule

// File: rtl/window_addr_gen.sv
// Expands each window top-left coordinate into K*K row-major input-SRAM read addresses.
module window_addr_gen
    import window_addr_gen_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = WAG_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_en,
    input  logic                  i_reg_clear,
    input  logic [ADDR_WIDTH-1:0] i_i_size,
    input  logic [ADDR_WIDTH-1:0] i_k_size,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    window_addr_gen_if.slave      bus,
    output logic                  o_busy
);
    localparam int unsigned AW = ADDR_WIDTH;

    wag_state_t    state_q;
    logic [AW-1:0] y_q;
    logic [AW-1:0] i_size_q;
    logic [AW-1:0] row_base_q;
    logic [AW-1:0] addr_q;
    logic          valid_q;

    logic [AW-1:0] kx;
    logic [AW-1:0] ky;
    logic          last;
    logic          wrap_c;

    logic          coord_ready_c;
    logic          accept_c;
    logic          beat_c;
    logic          advance_c;
    logic [AW-1:0] row_base_c;

    assign beat_c        = valid_q & bus.i_ready & i_en & ~i_reg_clear;
    assign coord_ready_c = i_en & ~i_reg_clear &
                           ((state_q == WAG_IDLE) | (valid_q & bus.i_ready & last));
    assign accept_c      = coord_ready_c & bus.i_coord_valid;
    // a final beat that also accepts a coordinate reloads instead of stepping
    assign advance_c     = beat_c & ~accept_c;
    assign row_base_c    = i_start_addr + bus.i_coord_x * i_i_size;

    kernel_pos_counter #(.W(AW)) u_kpos (
        .i_clk     (i_clk),
        .i_nrst    (i_nrst),
        .i_clear   (i_reg_clear),
        .i_load    (accept_c),
        .i_advance (advance_c),
        .i_k       (i_k_size),
        .o_kx      (kx),
        .o_ky      (ky),
        .o_last    (last),
        .o_wrap_c  (wrap_c)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= WAG_IDLE;
            y_q        <= '0;
            i_size_q   <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            o_busy     <= 1'b0;
        end else if (i_reg_clear) begin
            state_q    <= WAG_IDLE;
            row_base_q <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            o_busy     <= 1'b0;
        end else if (accept_c) begin
            state_q    <= WAG_EMIT;
            y_q        <= bus.i_coord_y;
            i_size_q   <= i_i_size;
            row_base_q <= row_base_c;
            addr_q     <= row_base_c + bus.i_coord_y;
            valid_q    <= 1'b1;
            o_busy     <= 1'b1;
        end else if (advance_c) begin
            if (last) begin
                state_q <= WAG_IDLE;
                valid_q <= 1'b0;
                o_busy  <= 1'b0;
            end else if (wrap_c) begin
                row_base_q <= row_base_q + i_size_q;
                addr_q     <= row_base_q + i_size_q + y_q;
            end else begin
                // equals row_base + y + ky for the next column
                addr_q <= addr_q + AW'(1);
            end
        end
    end

    assign bus.o_coord_ready = coord_ready_c;
    assign bus.o_addr        = addr_q;
    assign bus.o_kx          = kx;
    assign bus.o_ky          = ky;
    assign bus.o_valid       = valid_q;
    assign bus.o_last        = last;
endmodule

// File: tb/tb_window_addr_gen.sv
// Self-checking bench for window_addr_gen: directed table, corner sequences, random traffic vs model.
module tb_window_addr_gen;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          nrst;
    logic          en;
    logic          clr;
    logic [AW-1:0] isize;
    logic [AW-1:0] ksize;
    logic [AW-1:0] start;
    logic          busy;

    window_addr_gen_if #(.ADDR_WIDTH(AW)) bus ();

    window_addr_gen #(.ADDR_WIDTH(AW)) dut (
        .i_clk        (clk),
        .i_nrst       (nrst),
        .i_en         (en),
        .i_reg_clear  (clr),
        .i_i_size     (isize),
        .i_k_size     (ksize),
        .i_start_addr (start),
        .bus          (bus.slave),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] kx;
        logic [7:0] ky;
        logic       last;
    } beat_t;

    typedef struct {
        logic [7:0] isz;
        logic [7:0] k;
        logic [7:0] st;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] first;
        logic [7:0] lastaddr;
        int         beats;
    } vec_t;

    beat_t exp_q[$];
    int    n_chk   = 0;
    int    n_fail  = 0;
    int    n_beats = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every window is K*K addresses start + (x+r)*size + (y+c), mod 256
    task automatic push_window(input logic [7:0] s, input logic [7:0] isz, input logic [7:0] k,
                               input logic [7:0] x, input logic [7:0] y);
        int ke;
        ke = (k == 8'd0) ? 1 : int'(k);
        for (int r = 0; r < ke; r++) begin
            for (int c = 0; c < ke; c++) begin
                beat_t b;
                b.addr = 8'((int'(s) + (int'(x) + r) * int'(isz) + int'(y) + c) & 255);
                b.kx   = 8'(r);
                b.ky   = 8'(c);
                b.last = (r == ke - 1) && (c == ke - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // Scoreboard: checks every cycle's outputs against the expected beat stream
    always @(negedge clk) begin
        if (nrst === 1'b1) begin
            logic exp_cr;
            chk("valid", bus.o_valid, 32'(exp_q.size() != 0));
            chk("busy", busy, 32'(exp_q.size() != 0));
            exp_cr = en && !clr &&
                     (exp_q.size() == 0 || (exp_q.size() == 1 && bus.o_valid && bus.i_ready));
            chk("coord_ready", bus.o_coord_ready, 32'(exp_cr));
            if (bus.o_valid && exp_q.size() != 0) begin
                chk("addr", bus.o_addr, exp_q[0].addr);
                chk("kx", bus.o_kx, exp_q[0].kx);
                chk("ky", bus.o_ky, exp_q[0].ky);
                chk("last", bus.o_last, 32'(exp_q[0].last));
            end
            if (clr) begin
                exp_q.delete();
            end else if (en) begin
                if (bus.o_valid && bus.i_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    n_beats++;
                end
                if (bus.i_coord_valid && exp_cr)
                    push_window(start, isize, ksize, bus.i_coord_x, bus.i_coord_y);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] isz, input logic [7:0] k, input logic [7:0] st);
        isize = isz;
        ksize = k;
        start = st;
    endtask

    // Called just after a rising edge; returns just after the edge that accepts
    task automatic send_coord(input logic [7:0] x, input logic [7:0] y);
        bit got;
        got = 1'b0;
        bus.i_coord_x     = x;
        bus.i_coord_y     = y;
        bus.i_coord_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.o_coord_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("coord_accept_timeout", 32'(got), 32'd1);
        step();
        bus.i_coord_valid = 1'b0;
    endtask

    task automatic collect(output logic [7:0] first, output logic [7:0] lastaddr,
                           output int beats, output int lastcnt);
        bit done;
        done     = 1'b0;
        beats    = 0;
        lastcnt  = 0;
        first    = '0;
        lastaddr = '0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
            if (bus.o_valid && bus.i_ready && en) begin
                beats++;
                if (beats == 1) first = bus.o_addr;
                lastaddr = bus.o_addr;
                if (bus.o_last) lastcnt++;
            end
        end
        chk("collect_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[7];
        logic [7:0] first;
        logic [7:0] lastaddr;
        int         beats;
        int         lastcnt;
        int         run;
        bit         acc2;
        bit         pat[4];
        int         base;

        nrst              = 1'b0;
        en                = 1'b1;
        clr               = 1'b0;
        isize             = '0;
        ksize             = '0;
        start             = '0;
        bus.i_coord_valid = 1'b0;
        bus.i_coord_x     = '0;
        bus.i_coord_y     = '0;
        bus.i_ready       = 1'b1;

        #12 nrst = 1'b1;
        @(negedge clk);
        chk("rst_addr", bus.o_addr, 32'd0);
        chk("rst_kx", bus.o_kx, 32'd0);
        chk("rst_ky", bus.o_ky, 32'd0);
        chk("rst_valid", bus.o_valid, 32'd0);
        chk("rst_last", bus.o_last, 32'd0);
        chk("rst_busy", busy, 32'd0);
        step();

        // Directed windows with i_ready held high
        vecs[0] = '{8'd5,  8'd3, 8'h10, 8'd0, 8'd0,  8'h10, 8'h1C, 9};
        vecs[1] = '{8'd4,  8'd2, 8'hFE, 8'd0, 8'd0,  8'hFE, 8'h03, 4};
        vecs[2] = '{8'd8,  8'd0, 8'h00, 8'd3, 8'd4,  8'h1C, 8'h1C, 1};
        vecs[3] = '{8'd8,  8'd1, 8'h00, 8'd3, 8'd4,  8'h1C, 8'h1C, 1};
        vecs[4] = '{8'd5,  8'd3, 8'h10, 8'd1, 8'd1,  8'h16, 8'h22, 9};
        vecs[5] = '{8'd8,  8'd4, 8'h00, 8'd2, 8'd3,  8'h13, 8'h2E, 16};
        vecs[6] = '{8'd16, 8'd2, 8'hF0, 8'd0, 8'd14, 8'hFE, 8'h0F, 4};
        for (int i = 0; i < 7; i++) begin
            set_cfg(vecs[i].isz, vecs[i].k, vecs[i].st);
            send_coord(vecs[i].x, vecs[i].y);
            collect(first, lastaddr, beats, lastcnt);
            chk($sformatf("vec%0d_first", i), first, vecs[i].first);
            chk($sformatf("vec%0d_lastaddr", i), lastaddr, vecs[i].lastaddr);
            chk($sformatf("vec%0d_beats", i), 32'(beats), 32'(vecs[i].beats));
            chk($sformatf("vec%0d_lastcnt", i), 32'(lastcnt), 32'd1);
            step();
        end

        // Back-to-back windows: second coord accepted on the 0x1C beat, no bubble
        set_cfg(8'd5, 8'd3, 8'h10);
        bus.i_coord_x     = 8'd0;
        bus.i_coord_y     = 8'd0;
        bus.i_coord_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.o_coord_ready) break;
        end
        step();
        bus.i_coord_x = 8'd2;
        bus.i_coord_y = 8'd2;
        run  = 0;
        acc2 = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!bus.o_valid) break;
            run++;
            if (!acc2 && bus.o_coord_ready) begin
                acc2 = 1'b1;
                chk("b2b_accept_addr", bus.o_addr, 32'h1C);
                chk("b2b_accept_last", bus.o_last, 32'd1);
            end
            step();
            if (acc2) bus.i_coord_valid = 1'b0;
        end
        chk("b2b_accepted", 32'(acc2), 32'd1);
        chk("b2b_run", 32'(run), 32'd18);
        step();

        // Back-pressure with i_ready pattern 1,0,0,1
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        base = n_beats;
        send_coord(8'd0, 8'd0);
        for (int c = 0; c < 200; c++) begin
            bus.i_ready = pat[c % 4];
            @(negedge clk);
            if (!busy) break;
            step();
        end
        bus.i_ready = 1'b1;
        chk("bp_beats", 32'(n_beats - base), 32'd9);
        step();

        // Clear on the fourth beat, pending coordinate must not be taken
        send_coord(8'd0, 8'd0);
        step();
        step();
        step();
        clr               = 1'b1;
        bus.i_coord_x     = 8'd1;
        bus.i_coord_y     = 8'd1;
        bus.i_coord_valid = 1'b1;
        @(negedge clk);
        chk("clr_addr_beat4", bus.o_addr, 32'h15);
        chk("clr_no_accept", bus.o_coord_ready, 32'd0);
        step();
        clr = 1'b0;
        @(negedge clk);
        chk("clr_valid_low", bus.o_valid, 32'd0);
        chk("clr_busy_low", busy, 32'd0);
        chk("clr_ready_again", bus.o_coord_ready, 32'd1);
        step();
        bus.i_coord_valid = 1'b0;
        collect(first, lastaddr, beats, lastcnt);
        chk("clr_next_first", first, 32'h16);
        chk("clr_next_last", lastaddr, 32'h22);
        chk("clr_next_beats", 32'(beats), 32'd9);
        step();

        // Random traffic: random cfg, stalls, back-pressure, mid-window cfg churn
        for (int w = 0; w < 40; w++) begin
            int  ke;
            bit  got;
            logic [7:0] k;
            k     = 8'($urandom_range(0, 4));
            ke    = (k == 8'd0) ? 1 : int'(k);
            ksize = k;
            isize = 8'($urandom_range(ke, 12));
            start = 8'($urandom_range(0, 255));
            bus.i_coord_x     = 8'($urandom_range(0, int'(isize) - ke));
            bus.i_coord_y     = 8'($urandom_range(0, int'(isize) - ke));
            bus.i_coord_valid = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 400; c++) begin
                bus.i_ready = ($urandom_range(0, 3) != 0);
                en          = ($urandom_range(0, 9) != 0);
                @(negedge clk);
                got = bus.o_coord_ready;
                step();
                if (got) break;
            end
            chk("rand_accept_timeout", 32'(got), 32'd1);
            bus.i_coord_valid = 1'b0;
            isize = 8'($urandom_range(0, 255));
            ksize = 8'($urandom_range(0, 255));
            start = 8'($urandom_range(0, 255));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                bus.i_ready = ($urandom_range(0, 3) != 0);
                en          = ($urandom_range(0, 9) != 0);
                step();
            end
        end
        bus.i_ready = 1'b1;
        en          = 1'b1;
        collect(first, lastaddr, beats, lastcnt);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
